collide_tick: RTL and testbench

COLLIDE_TICK -- requirements
Module: collide_tick

---
 rtl/collide_tick_pkg.sv | 23 ++
 rtl/collide_tick_hit_test.sv | 44 ++++
 rtl/collide_tick.sv | 137 +++++++++++++
 tb/tb_collide_tick.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/collide_tick_pkg.sv
// Shared game definitions: FSM encodings, screen/sprite geometry and small helpers
// used by the bird/wall controllers and the collision tick block.
package collide_tick_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HIT  = 2'd2
   } game_state_e;

   localparam int FRAME_CYCLES_DEF = 833333;
   localparam int BIRD_X_DEF       = 40;
   localparam int BIRD_W_DEF       = 8;
   localparam int BIRD_H_DEF       = 8;
   localparam int WALL_W_DEF       = 16;
   localparam int GAP_H_DEF        = 40;
   localparam int SCREEN_H_DEF     = 120;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'd255) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/collide_tick_hit_test.sv
// Combinational bird-vs-wall/floor geometry test plus the "wall just passed" check.
// All sums are widened to 9 bits so large wall_x values cannot wrap into a false match.
module hit_test
   import collide_tick_pkg::*;
#(
   parameter int BIRD_X   = BIRD_X_DEF,
   parameter int BIRD_W   = BIRD_W_DEF,
   parameter int BIRD_H   = BIRD_H_DEF,
   parameter int WALL_W   = WALL_W_DEF,
   parameter int GAP_H    = GAP_H_DEF,
   parameter int SCREEN_H = SCREEN_H_DEF
) (
   input  logic [6:0] bird_y,
   input  logic [7:0] wall_x,
   input  logic [6:0] gap_y,
   output logic       hit,
   output logic       pass
);

   logic [8:0] wall_l_s;
   logic [8:0] wall_r_s;
   logic [8:0] bird_t_s;
   logic [8:0] bird_b_s;
   logic [8:0] gap_t_s;
   logic [8:0] gap_b_s;
   logic       overlap_s;
   logic       out_gap_s;
   logic       floor_s;

   assign wall_l_s = {1'b0, wall_x};
   assign wall_r_s = wall_l_s + 9'(WALL_W - 1);
   assign bird_t_s = {2'b00, bird_y};
   assign bird_b_s = bird_t_s + 9'(BIRD_H);
   assign gap_t_s  = {2'b00, gap_y};
   assign gap_b_s  = gap_t_s + 9'(GAP_H);

   assign overlap_s = (wall_l_s <= 9'(BIRD_X + BIRD_W - 1)) && (wall_r_s >= 9'(BIRD_X));
   assign out_gap_s = (bird_t_s < gap_t_s) || (bird_b_s > gap_b_s);
   assign floor_s   = (bird_b_s >= 9'(SCREEN_H));

   assign hit  = (overlap_s && out_gap_s) || floor_s;
   assign pass = ((wall_l_s + 9'(WALL_W)) == 9'(BIRD_X));

endmodule

// File: rtl/collide_tick.sv
// Frame-tick generator and game FSM: pulses flag once per frame while running and
// evaluates collision/score on that tick. Every output comes straight from a register.
module collide_tick
   import collide_tick_pkg::*;
#(
   parameter int FRAME_CYCLES = FRAME_CYCLES_DEF,
   parameter int BIRD_X       = BIRD_X_DEF,
   parameter int BIRD_W       = BIRD_W_DEF,
   parameter int BIRD_H       = BIRD_H_DEF,
   parameter int WALL_W       = WALL_W_DEF,
   parameter int GAP_H        = GAP_H_DEF,
   parameter int SCREEN_H     = SCREEN_H_DEF
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       go,
   input  logic [6:0] bird_y,
   input  logic [7:0] wall_x,
   input  logic [6:0] gap_y,
   output logic       flag,
   output logic       collision,
   output logic [7:0] score,
   output logic [1:0] state
);

   localparam int               CNT_W    = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_CYCLES - 1);

   logic [1:0]       state_r;
   logic [1:0]       state_next_s;
   logic [CNT_W-1:0] cnt_r;
   logic [CNT_W-1:0] cnt_next_s;
   logic             flag_r;
   logic             flag_next_s;
   logic             collision_r;
   logic             collision_next_s;
   logic [7:0]       score_r;
   logic [7:0]       score_next_s;
   logic             hit_s;
   logic             pass_s;
   logic             eval_s;

   hit_test #(
      .BIRD_X   (BIRD_X),
      .BIRD_W   (BIRD_W),
      .BIRD_H   (BIRD_H),
      .WALL_W   (WALL_W),
      .GAP_H    (GAP_H),
      .SCREEN_H (SCREEN_H)
   ) u_hit_test (
      .bird_y (bird_y),
      .wall_x (wall_x),
      .gap_y  (gap_y),
      .hit    (hit_s),
      .pass   (pass_s)
   );

   // flag_r is high exactly while the counter sits on its last value in RUN
   assign eval_s = flag_r && (state_r == ST_RUN);

   // State, frame counter and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (resetn) begin
         state_r     <= ST_IDLE;
         cnt_r       <= '0;
         flag_r      <= 1'b0;
         collision_r <= 1'b0;
         score_r     <= 8'd0;
      end else begin
         state_r     <= state_next_s;
         cnt_r       <= cnt_next_s;
         flag_r      <= flag_next_s;
         collision_r <= collision_next_s;
         score_r     <= score_next_s;
      end
   end

   // Next-state decode; the unused encoding falls back to IDLE
   always_comb begin
      state_next_s = ST_IDLE;
      case (state_r)
         ST_IDLE: begin
            if (go) state_next_s = ST_RUN;
            else    state_next_s = ST_IDLE;
         end
         ST_RUN: begin
            if (eval_s && hit_s) state_next_s = ST_HIT;
            else                 state_next_s = ST_RUN;
         end
         ST_HIT: begin
            if (go) state_next_s = ST_IDLE;
            else    state_next_s = ST_HIT;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // Next values of counter, collision and score
   always_comb begin
      cnt_next_s       = '0;
      collision_next_s = collision_r;
      score_next_s     = score_r;
      case (state_r)
         ST_IDLE: begin
            collision_next_s = 1'b0;
            score_next_s     = 8'd0;
         end
         ST_RUN: begin
            if ((cnt_r == CNT_LAST) || (state_next_s != ST_RUN)) cnt_next_s = '0;
            else                                                 cnt_next_s = cnt_r + CNT_W'(1);
            if (eval_s && hit_s)       collision_next_s = 1'b1;
            else if (eval_s && pass_s) score_next_s     = sat_inc8(score_r);
            else                       score_next_s     = score_r;
         end
         ST_HIT: begin
            if (go) begin
               collision_next_s = 1'b0;
               score_next_s     = 8'd0;
            end else begin
               collision_next_s = 1'b1;
            end
         end
         default: begin
            collision_next_s = 1'b0;
            score_next_s     = 8'd0;
         end
      endcase
   end

   assign flag_next_s = (state_next_s == ST_RUN) && (cnt_next_s == CNT_LAST);

   assign flag      = flag_r;
   assign collision = collision_r;
   assign score     = score_r;
   assign state     = state_r;

endmodule

// File: tb/tb_collide_tick.sv
// Self-checking bench for collide_tick with a short frame: table-driven geometry
// vectors through a scoreboard queue, plus hand-written multi-cycle sequences.
module tb_collide_tick;

   localparam int FC = 10;

   logic       clk    = 1'b0;
   logic       resetn = 1'b1;
   logic       go     = 1'b0;
   logic [6:0] bird_y = 7'd50;
   logic [7:0] wall_x = 8'd200;
   logic [6:0] gap_y  = 7'd40;
   logic       flag;
   logic       collision;
   logic [7:0] score;
   logic [1:0] state;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      int st;
      int col;
      int sc;
   } exp_t;

   typedef struct {
      int by;
      int wx;
      int gy;
      int e_hit;
      int e_pass;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[16];

   collide_tick #(.FRAME_CYCLES(FC)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .go        (go),
      .bird_y    (bird_y),
      .wall_x    (wall_x),
      .gap_y     (gap_y),
      .flag      (flag),
      .collision (collision),
      .score     (score),
      .state     (state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_flag(output int n);
      n = 0;
      while (flag !== 1'b1 && n < 4 * FC) begin
         step();
         n++;
      end
      if (flag !== 1'b1) begin
         checks++;
         failures++;
         $display("FAIL wait_flag timeout actual_cycles=%0d expected_flag_within=%0d", n, 4 * FC);
      end
   endtask

   task automatic restart();
      resetn = 1'b1;
      step();
      resetn = 1'b0;
      go = 1'b1;
      step();
      go = 1'b0;
   endtask

   task automatic safe_inputs();
      bird_y = 7'd50;
      wall_x = 8'd200;
      gap_y  = 7'd40;
   endtask

   task automatic push_exp(input int s, input int c, input int sc);
      exp_t e;
      e.st  = s;
      e.col = c;
      e.sc  = sc;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (sb.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s scoreboard_empty actual=0 expected=1", tag);
      end else begin
         e = sb.pop_front();
         chk({tag, "_state"}, int'(state), e.st);
         chk({tag, "_collision"}, int'(collision), e.col);
         chk({tag, "_score"}, int'(score), e.sc);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int seen;
      int eh;
      int ep;

      // bird_y, wall_x, gap_y, expected hit, expected pass
      vecs[0]  = '{50, 36, 40, 0, 0};
      vecs[1]  = '{50, 24, 40, 0, 1};
      vecs[2]  = '{20, 40, 40, 1, 0};
      vecs[3]  = '{113, 200, 40, 1, 0};
      vecs[4]  = '{72, 40, 40, 0, 0};
      vecs[5]  = '{73, 40, 40, 1, 0};
      vecs[6]  = '{40, 40, 40, 0, 0};
      vecs[7]  = '{39, 40, 40, 1, 0};
      vecs[8]  = '{20, 47, 40, 1, 0};
      vecs[9]  = '{20, 48, 40, 0, 0};
      vecs[10] = '{20, 25, 40, 1, 0};
      vecs[11] = '{20, 24, 40, 0, 1};
      vecs[12] = '{112, 200, 40, 1, 0};
      vecs[13] = '{111, 200, 40, 0, 0};
      vecs[14] = '{113, 24, 40, 1, 0};
      vecs[15] = '{20, 250, 40, 0, 0};

      step();
      step();
      chk("reset_state", int'(state), 0);
      chk("reset_flag", int'(flag), 0);
      chk("reset_collision", int'(collision), 0);
      chk("reset_score", int'(score), 0);
      resetn = 1'b0;
      step();
      step();
      chk("idle_hold_state", int'(state), 0);
      chk("idle_flag", int'(flag), 0);

      go = 1'b1;
      step();
      go = 1'b0;
      chk("enter_run", int'(state), 1);
      wait_flag(n);
      chk("first_flag_delay", n, FC - 1);
      step();
      chk("flag_width", int'(flag), 0);
      wait_flag(n);
      chk("flag_period", n, FC - 1);
      step();
      go = 1'b1;
      step();
      go = 1'b0;
      chk("go_in_run_ignored", int'(state), 1);

      for (int i = 0; i < 16; i++) begin
         restart();
         bird_y = 7'(vecs[i].by);
         wall_x = 8'(vecs[i].wx);
         gap_y  = 7'(vecs[i].gy);
         wait_flag(n);
         eh = vecs[i].e_hit;
         ep = vecs[i].e_pass;
         push_exp((eh != 0) ? 2 : 1, eh, ((eh == 0) && (ep != 0)) ? 1 : 0);
         step();
         pop_check($sformatf("vec%0d", i));
         safe_inputs();
      end

      // pass, then hit: score kept, flags stop, go clears back to IDLE
      restart();
      bird_y = 7'd50;
      wall_x = 8'd24;
      wait_flag(n);
      push_exp(1, 0, 1);
      step();
      pop_check("seq_pass");
      bird_y = 7'd20;
      wall_x = 8'd40;
      wait_flag(n);
      push_exp(2, 1, 1);
      step();
      pop_check("seq_hit");
      seen = 0;
      for (int k = 0; k < 3 * FC; k++) begin
         step();
         if (flag === 1'b1) seen = 1;
      end
      chk("no_flag_in_hit", seen, 0);
      chk("hit_sticky", int'(collision), 1);
      go = 1'b1;
      step();
      go = 1'b0;
      chk("hit_go_state", int'(state), 0);
      chk("hit_go_collision", int'(collision), 0);
      chk("hit_go_score", int'(score), 0);
      safe_inputs();

      // saturation at 255, then reset in the middle of a frame
      restart();
      bird_y = 7'd50;
      wall_x = 8'd24;
      for (int k = 0; k < 255; k++) begin
         wait_flag(n);
         step();
      end
      chk("score_255", int'(score), 255);
      wait_flag(n);
      push_exp(1, 0, 255);
      step();
      pop_check("saturate");
      for (int k = 0; k < 5; k++) step();
      resetn = 1'b1;
      step();
      resetn = 1'b0;
      chk("midframe_reset_state", int'(state), 0);
      chk("midframe_reset_flag", int'(flag), 0);
      chk("midframe_reset_collision", int'(collision), 0);
      chk("midframe_reset_score", int'(score), 0);
      safe_inputs();
      go = 1'b1;
      step();
      go = 1'b0;
      wait_flag(n);
      chk("post_reset_flag_delay", n, FC - 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
